rs232_uart_ctrl: RTL and testbench

Full-duplex RS232 UART controller with an integrated baud-rate generator. It deserialises frames on rx into a parallel byte and pulses new_word. It serialises a byte on tx when send_word is asserted. Frame format: 1 start bit (0), 8 data bits MSB first, 1 odd-parity bit, 1 stop bit (1). It sits between the RS232 pins and the memory/word interface.

---
 rtl/rs232_uart_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_rs232_uart_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs232_uart_ctrl.sv
// +----------------------------------------------------------------------------+
// | rs232_uart_ctrl                                                              |
// | Full-duplex RS232 UART: 8 data bits MSB first, odd parity, 1 stop bit.      |
// | Revision: 1.0                                                                |
// +----------------------------------------------------------------------------+
`default_nettype none

module rs232_uart_ctrl #(
  parameter int CLKS_PER_BIT = 10417,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              send_word,
  input  logic [DATA_W-1:0] data_rs232_out,
  output logic              new_word,
  output logic [DATA_W-1:0] data_rs232_in,
  output logic              parity_err,
  output logic              frame_err,
  output logic              tx_busy,
  input  logic              rx,
  output logic              tx
);

  localparam int c_cnt_w = $clog2(CLKS_PER_BIT);
  localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);
  localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2);
  localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_start  = 3'd1;
  localparam logic [2:0] c_st_data   = 3'd2;
  localparam logic [2:0] c_st_parity = 3'd3;
  localparam logic [2:0] c_st_stop   = 3'd4;

  // ---------------------------------------------------------------- receiver
  logic               r_rx_meta, r_rx_sync, r_rx_prev;
  logic [2:0]         r_rx_state, w_rx_state_next;
  logic [c_cnt_w-1:0] r_rx_cnt;
  logic [c_idx_w-1:0] r_rx_idx;
  logic [DATA_W-1:0]  r_rx_shift;
  logic               r_rx_par;
  logic               w_rx_tick, w_rx_mid_start, w_rx_fall, w_rx_par_ok;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_state <= c_st_idle;
    else      r_rx_state <= w_rx_state_next;
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      c_st_idle:   if (w_rx_fall) w_rx_state_next = c_st_start;
      c_st_start:  if (w_rx_mid_start) w_rx_state_next = r_rx_sync ? c_st_idle : c_st_data;
      c_st_data:   if (w_rx_tick && (r_rx_idx == c_idx_last)) w_rx_state_next = c_st_parity;
      c_st_parity: if (w_rx_tick) w_rx_state_next = c_st_stop;
      c_st_stop:   if (w_rx_tick) w_rx_state_next = c_st_idle;
      default:     w_rx_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    w_rx_fall      = r_rx_prev & ~r_rx_sync;
    w_rx_tick      = (r_rx_cnt == c_cnt_last);
    w_rx_mid_start = (r_rx_state == c_st_start) && (r_rx_cnt == c_cnt_half);
    w_rx_par_ok    = ^{r_rx_shift, r_rx_par};
  end

  // Counter is rezeroed at mid start bit so every later tick lands mid-bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_cnt      <= '0;
      r_rx_idx      <= '0;
      r_rx_shift    <= '0;
      r_rx_par      <= 1'b0;
      data_rs232_in <= '0;
      new_word      <= 1'b0;
      parity_err    <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      new_word   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (r_rx_state)
        c_st_start: r_rx_cnt <= w_rx_mid_start ? '0 : r_rx_cnt + c_cnt_one;
        c_st_data: begin
          r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + c_cnt_one;
          if (w_rx_tick) begin
            r_rx_shift <= {r_rx_shift[DATA_W-2:0], r_rx_sync};
            r_rx_idx   <= r_rx_idx + c_idx_one;
          end
        end
        c_st_parity: begin
          r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + c_cnt_one;
          if (w_rx_tick) r_rx_par <= r_rx_sync;
        end
        c_st_stop: begin
          r_rx_cnt <= w_rx_tick ? '0 : r_rx_cnt + c_cnt_one;
          if (w_rx_tick) begin
            new_word   <= r_rx_sync & w_rx_par_ok;
            parity_err <= ~w_rx_par_ok;
            frame_err  <= ~r_rx_sync;
            if (r_rx_sync && w_rx_par_ok) data_rs232_in <= r_rx_shift;
          end
        end
        default: begin
          r_rx_cnt <= '0;
          r_rx_idx <= '0;
        end
      endcase
    end
  end

  // ------------------------------------------------------------- transmitter
  logic [2:0]         r_tx_state, w_tx_state_next;
  logic [c_cnt_w-1:0] r_tx_cnt;
  logic [c_idx_w-1:0] r_tx_idx;
  logic [DATA_W-1:0]  r_tx_data;
  logic               r_tx_par;
  logic               w_tx_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_tx_state <= c_st_idle;
    else      r_tx_state <= w_tx_state_next;
  end

  always_comb begin
    w_tx_state_next = r_tx_state;
    case (r_tx_state)
      c_st_idle:   if (send_word) w_tx_state_next = c_st_start;
      c_st_start:  if (w_tx_tick) w_tx_state_next = c_st_data;
      c_st_data:   if (w_tx_tick && (r_tx_idx == '0)) w_tx_state_next = c_st_parity;
      c_st_parity: if (w_tx_tick) w_tx_state_next = c_st_stop;
      c_st_stop:   if (w_tx_tick) w_tx_state_next = c_st_idle;
      default:     w_tx_state_next = c_st_idle;
    endcase
  end

  // Line level decodes straight from state flops so reset forces idle at once
  always_comb begin
    w_tx_tick = (r_tx_cnt == c_cnt_last);
    tx_busy   = (r_tx_state != c_st_idle);
    case (r_tx_state)
      c_st_start:  tx = 1'b0;
      c_st_data:   tx = r_tx_data[r_tx_idx];
      c_st_parity: tx = r_tx_par;
      default:     tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_cnt  <= '0;
      r_tx_idx  <= '0;
      r_tx_data <= '0;
      r_tx_par  <= 1'b0;
    end else begin
      case (r_tx_state)
        c_st_idle: begin
          r_tx_cnt <= '0;
          if (send_word) begin
            r_tx_data <= data_rs232_out;
            r_tx_par  <= ~^data_rs232_out;
            r_tx_idx  <= c_idx_last;
          end
        end
        c_st_data: begin
          r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + c_cnt_one;
          if (w_tx_tick) r_tx_idx <= r_tx_idx - c_idx_one;
        end
        default: r_tx_cnt <= w_tx_tick ? '0 : r_tx_cnt + c_cnt_one;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rs232_uart_ctrl.sv
// Scoreboard bench for rs232_uart_ctrl: queued expectations, independent RX/TX monitors.
`timescale 1ns/1ps
`default_nettype none

module tb_rs232_uart_ctrl;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send_word = 1'b0;
  logic [7:0] data_rs232_out = 8'h00;
  logic       rx = 1'b1;
  logic       new_word, parity_err, frame_err, tx_busy, tx;
  logic [7:0] data_rs232_in;

  rs232_uart_ctrl #(.CLKS_PER_BIT(CPB), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .send_word(send_word), .data_rs232_out(data_rs232_out),
    .new_word(new_word), .data_rs232_in(data_rs232_in), .parity_err(parity_err),
    .frame_err(frame_err), .tx_busy(tx_busy), .rx(rx), .tx(tx)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [10:0] rx_exp_q[$];   // {new_word, parity_err, frame_err, data}
  logic [7:0]  tx_exp_q[$];
  logic [7:0]  last_good = 8'h00;
  bit          tx_abort_frame = 1'b0;
  bit          tx_abort_busy = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line-level frame: start, data MSB first, parity, stop
  task automatic rx_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic [10:0] bits;
    logic p;
    p = (~^b) ^ bad_par;
    bits = {1'b0, b, p, ~bad_stop};
    if (!bad_par && !bad_stop) begin
      rx_exp_q.push_back({3'b100, b});
      last_good = b;
    end else begin
      rx_exp_q.push_back({1'b0, bad_par, bad_stop, last_good});
    end
    for (int i = 10; i >= 0; i--) begin
      rx = bits[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic wait_tx_idle(input string name);
    int t;
    t = 0;
    while (tx_busy && t < 13 * CPB) begin
      @(negedge clk);
      t++;
    end
    check(name, tx_busy, 1'b0);
  endtask

  task automatic tx_send(input logic [7:0] b);
    int t;
    t = 0;
    while (tx_busy && t < 13 * CPB) begin
      @(negedge clk);
      t++;
    end
    if (tx_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tx_wait: tx_busy=1, expected 0 before send");
    end
    data_rs232_out = b;
    send_word = 1'b1;
    tx_exp_q.push_back(b);
    @(negedge clk);
    send_word = 1'b0;
    data_rs232_out = 8'($urandom);
  endtask

  // RX monitor: every reported event must match the head of the queue
  initial begin : rx_mon
    logic [10:0] e;
    forever begin
      @(negedge clk);
      if (rst && (new_word || parity_err || frame_err)) begin
        if (rx_exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL rx_unexpected: got nw=%0b pe=%0b fe=%0b data=0x%02h, expected no event",
                   new_word, parity_err, frame_err, data_rs232_in);
        end else begin
          e = rx_exp_q.pop_front();
          check("rx_event", {new_word, parity_err, frame_err, data_rs232_in}, e);
        end
      end
    end
  end

  // TX monitor: decode the serial line by mid-bit sampling
  initial begin : tx_mon
    logic [10:0] f, e;
    logic [7:0]  b;
    logic        tprev;
    tprev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst && tprev && !tx) begin
        repeat (CPB / 2) @(negedge clk);
        f[10] = tx;
        for (int i = 9; i >= 0; i--) begin
          repeat (CPB) @(negedge clk);
          f[i] = tx;
        end
        if (tx_exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL tx_unexpected: got frame 0x%03h, expected no frame", f);
        end else begin
          b = tx_exp_q.pop_front();
          e = {1'b0, b, ~^b, 1'b1};
          if (tx_abort_frame) tx_abort_frame = 1'b0;
          else check("tx_frame", f, e);
        end
        tprev = 1'b1;
      end else begin
        tprev = tx;
      end
    end
  end

  initial begin : busy_mon
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (tx_busy) cnt++;
      else if (cnt != 0) begin
        if (tx_abort_busy) tx_abort_busy = 1'b0;
        else check("tx_busy_len", cnt, 11 * CPB);
        cnt = 0;
      end
    end
  end

  initial begin : stim
    int bad;
    int t;
    logic [7:0] rb;
    int r;

    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("reset_tx", tx, 1'b1);
    check("reset_tx_busy", tx_busy, 1'b0);
    check("reset_new_word", new_word, 1'b0);
    check("reset_errs", {parity_err, frame_err}, 2'b00);
    check("reset_data", data_rs232_in, 8'h00);
    rst = 1'b1;
    bad = 0;
    repeat (3 * CPB) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0 || data_rs232_in !== 8'h00) bad++;
    end
    check("idle_stable", bad, 0);

    rx_frame(8'h0D, 1'b0, 1'b0);

    // Mid-frame send_word with other data must be ignored
    tx_send(8'h0A);
    repeat (3 * CPB) @(negedge clk);
    data_rs232_out = 8'hFF;
    send_word = 1'b1;
    @(negedge clk);
    send_word = 1'b0;
    wait_tx_idle("tx_0a_done");

    rx_frame(8'h0B, 1'b1, 1'b0);
    check("hold_after_perr", data_rs232_in, last_good);
    rx_frame(8'h55, 1'b0, 1'b1);
    rx_frame(8'h96, 1'b1, 1'b1);

    rx = 1'b0;
    repeat (CPB / 4) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    rx_frame(8'hE7, 1'b0, 1'b0);

    fork
      tx_send(8'hA5);
      rx_frame(8'h3C, 1'b0, 1'b0);
    join
    wait_tx_idle("duplex_done");

    // Level-held send_word: second frame picks up the data present at re-entry
    data_rs232_out = 8'h81;
    send_word = 1'b1;
    tx_exp_q.push_back(8'h81);
    tx_exp_q.push_back(8'h7E);
    @(negedge clk);
    data_rs232_out = 8'h7E;
    t = 0;
    while (tx_busy && t < 13 * CPB) begin
      @(negedge clk);
      t++;
    end
    check("b2b_gap", tx_busy, 1'b0);
    @(negedge clk);
    send_word = 1'b0;
    wait_tx_idle("b2b_done");

    tx_send(8'hC3);
    repeat (4 * CPB) @(negedge clk);
    tx_abort_frame = 1'b1;
    tx_abort_busy = 1'b1;
    rst = 1'b0;
    last_good = 8'h00;
    #1;
    check("abort_tx", tx, 1'b1);
    check("abort_busy", tx_busy, 1'b0);
    check("abort_data", data_rs232_in, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    repeat (12 * CPB) @(negedge clk);
    tx_send(8'h3A);
    wait_tx_idle("post_abort_done");

    fork
      begin
        for (int i = 0; i < 10; i++) begin
          rb = 8'($urandom);
          r = $urandom_range(0, 5);
          rx_frame(rb, (r == 1) || (r == 3), (r == 2) || (r == 3));
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          tx_send(8'($urandom));
          repeat ($urandom_range(0, 2 * CPB)) @(negedge clk);
        end
      end
    join

    t = 0;
    while ((rx_exp_q.size() != 0 || tx_exp_q.size() != 0) && t < 30 * CPB) begin
      @(negedge clk);
      t++;
    end
    check("rx_queue_drained", rx_exp_q.size(), 0);
    check("tx_queue_drained", tx_exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
